interrupt_sequencer: RTL and testbench

- Sits between the interrupt controller and the CPU core, downstream of the controller's next_interrupt output.
- Decides when a pending interrupt may preempt the running code, and performs the request/acknowledge handshake with the CPU.
- After acknowledge, issues the dismiss for the taken vector and tracks nested priority levels on a small stack.
- Also owns the controller's shared dismiss/create/data_in bus and arbitrates CPU software-interrupt creation onto it.

---
 rtl/interrupt_sequencer.sv | 144 ++++++++++++++
 tb/tb_interrupt_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: gates controller interrupts onto the CPU request/ack handshake, tracks nested levels, and arbitrates the shared controller bus.
// Optional: define INTSEQ_ACK_TIMEOUT_EN to abandon unacknowledged requests after TIMEOUT_CYCLES and raise sticky ack_timeout.
module interrupt_sequencer #(
  parameter int NEST_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] next_interrupt,
  input  logic        boundary,
  input  logic        ie_set,
  input  logic        ie_clr,
  input  logic        iret,
  input  logic        int_ack,
  input  logic        sw_create,
  input  logic [11:0] sw_data,
  output logic        int_req,
  output logic [11:0] int_vector,
  output logic        ctrl_dismiss,
  output logic        ctrl_create,
  output logic [11:0] ctrl_data,
  output logic [11:0] cur_level,
`ifdef INTSEQ_ACK_TIMEOUT_EN
  output logic        ack_timeout,
`endif
  output logic        nest_err
);

  localparam logic [11:0] NONE = 12'o7777;
  localparam int DW = $clog2(NEST_DEPTH + 1);

  if (NEST_DEPTH < 1 || NEST_DEPTH > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("interrupt_sequencer: NEST_DEPTH must be 1..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, DISMISS, SETTLE} state_t;

  state_t          state, state_nxt;
  logic            ie;
  logic [DW-1:0]   depth;
  logic [11:0]     stack [2**DW];
  logic            sw_valid;
  logic [11:0]     sw_buf;
  logic            full, take, push, pop_ok, to_hit;

  assign full   = (depth == DW'(NEST_DEPTH));
  assign take   = ie && boundary && (next_interrupt != NONE) &&
                  (next_interrupt < cur_level) && !full;
  assign push   = (state == REQ) && int_ack;
  assign pop_ok = iret && (depth != '0);

`ifdef INTSEQ_ACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  assign to_hit = (state == REQ) && !int_ack && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt      <= '0;
      ack_timeout <= 1'b0;
    end else begin
      to_cnt <= (state == REQ && !to_hit) ? to_cnt + TW'(1) : '0;
      if (to_hit) ack_timeout <= 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // NOTE: every output and next_state gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt    = state;
    int_req      = 1'b0;
    ctrl_dismiss = 1'b0;
    ctrl_create  = 1'b0;
    ctrl_data    = NONE;
    case (state)
      IDLE:    if (take) state_nxt = REQ;
      REQ: begin
        int_req = 1'b1;
        if (int_ack)     state_nxt = DISMISS;
        else if (to_hit) state_nxt = IDLE;
      end
      DISMISS: begin
        ctrl_dismiss = 1'b1;
        ctrl_data    = int_vector;
        state_nxt    = SETTLE;
      end
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // The software create yields the bus only to the dismiss.
    if (sw_valid && state != DISMISS) begin
      ctrl_create = 1'b1;
      ctrl_data   = sw_buf;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      int_vector <= '0;
      ie         <= 1'b0;
      cur_level  <= NONE;
      depth      <= '0;
      nest_err   <= 1'b0;
      sw_valid   <= 1'b0;
      sw_buf     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && take) int_vector <= next_interrupt;

      if (ie_clr)      ie <= 1'b0;
      else if (ie_set) ie <= 1'b1;

      // Simultaneous pop and push leaves the stack top in place; only cur_level moves.
      if (pop_ok && push) begin
        cur_level <= int_vector;
      end else if (pop_ok) begin
        cur_level <= stack[depth - DW'(1)];
        depth     <= depth - DW'(1);
      end else if (push) begin
        cur_level <= int_vector;
        depth     <= depth + DW'(1);
      end
      if (iret && depth == '0) nest_err <= 1'b1;

      if (sw_create) begin
        sw_valid <= 1'b1;
        sw_buf   <= sw_data;
      end else if (ctrl_create) begin
        sw_valid <= 1'b0;
      end
    end
  end

  // NOTE: stack storage has no reset; depth alone says which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push && !pop_ok) stack[depth] <= cur_level;
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer (NEST_DEPTH = 2): vector table plus hand sequences for reset and timeout.
module tb_interrupt_sequencer;

  localparam logic [11:0] N = 12'o7777;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] next_interrupt;
  logic        boundary, ie_set, ie_clr, iret, int_ack, sw_create;
  logic [11:0] sw_data;
  logic        int_req, ctrl_dismiss, ctrl_create, nest_err;
  logic [11:0] int_vector, ctrl_data, cur_level;
`ifdef INTSEQ_ACK_TIMEOUT_EN
  logic        ack_timeout;
`endif

  int total = 0;
  int bad   = 0;

  interrupt_sequencer #(.NEST_DEPTH(2), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .next_interrupt(next_interrupt), .boundary(boundary),
    .ie_set(ie_set), .ie_clr(ie_clr), .iret(iret), .int_ack(int_ack),
    .sw_create(sw_create), .sw_data(sw_data), .int_req(int_req), .int_vector(int_vector),
    .ctrl_dismiss(ctrl_dismiss), .ctrl_create(ctrl_create), .ctrl_data(ctrl_data),
    .cur_level(cur_level),
`ifdef INTSEQ_ACK_TIMEOUT_EN
    .ack_timeout(ack_timeout),
`endif
    .nest_err(nest_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ie_set, ie_clr, boundary, iret, int_ack, sw_create;
    logic [11:0] ni, sw_data;
    logic [39:0] exp; // {req, vector, dismiss, create, data, level, nest_err}
  } vec_t;

  vec_t tbl [29];

  function automatic vec_t mk(input logic s, c, b, input logic [11:0] ni, input logic ir, ak, sc,
                              input logic [11:0] sd, input logic rq, input logic [11:0] vc,
                              input logic ds, cr, input logic [11:0] dt, lv, input logic er);
    vec_t v;
    v.ie_set = s; v.ie_clr = c; v.boundary = b; v.ni = ni; v.iret = ir; v.int_ack = ak;
    v.sw_create = sc; v.sw_data = sd;
    v.exp = {rq, vc, ds, cr, dt, lv, er};
    return v;
  endfunction

  function automatic logic [39:0] outs();
    return {int_req, int_vector, ctrl_dismiss, ctrl_create, ctrl_data, cur_level, nest_err};
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, c, b, input logic [11:0] ni, input logic ir, ak, sc,
                       input logic [11:0] sd);
    @(negedge clk);
    ie_set = s; ie_clr = c; boundary = b; next_interrupt = ni;
    iret = ir; int_ack = ak; sw_create = sc; sw_data = sd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    drive(0, 0, 0, N, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ie_set = 0; ie_clr = 0; boundary = 0; next_interrupt = N;
    iret = 0; int_ack = 0; sw_create = 0; sw_data = '0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    //          s c b ni   ir ak sc sd     | rq vc ds cr dt     lv er
    tbl[0]  = mk(1,0,0,N,    0,0,0,0,      0,0,0,0,N,        N,0);
    tbl[1]  = mk(0,0,1,2,    0,0,0,0,      1,2,0,0,N,        N,0);
    tbl[2]  = mk(0,0,1,2,    0,0,0,0,      1,2,0,0,N,        N,0);
    tbl[3]  = mk(0,0,1,1,    0,0,0,0,      1,2,0,0,N,        N,0);
    tbl[4]  = mk(0,0,0,1,    0,1,0,0,      0,2,1,0,2,        2,0);
    tbl[5]  = mk(0,0,1,5,    0,0,0,0,      0,2,0,0,N,        2,0);
    tbl[6]  = mk(0,0,1,5,    0,0,0,0,      0,2,0,0,N,        2,0);
    tbl[7]  = mk(0,0,1,5,    0,0,0,0,      0,2,0,0,N,        2,0);
    tbl[8]  = mk(0,0,1,1,    0,0,0,0,      1,1,0,0,N,        2,0);
    tbl[9]  = mk(0,0,1,1,    0,1,1,12'o30, 0,1,1,0,1,        1,0);
    tbl[10] = mk(0,0,0,N,    0,0,0,0,      0,1,0,1,12'o30,   1,0);
    tbl[11] = mk(0,0,1,0,    0,0,0,0,      0,1,0,0,N,        1,0);
    tbl[12] = mk(0,0,1,0,    0,0,0,0,      0,1,0,0,N,        1,0);
    tbl[13] = mk(0,0,1,0,    0,0,0,0,      0,1,0,0,N,        1,0);
    tbl[14] = mk(0,0,1,0,    1,0,0,0,      0,1,0,0,N,        2,0);
    tbl[15] = mk(0,0,1,0,    0,0,0,0,      1,0,0,0,N,        2,0);
    tbl[16] = mk(0,0,0,N,    1,1,0,0,      0,0,1,0,0,        0,0);
    tbl[17] = mk(0,0,0,N,    0,0,0,0,      0,0,0,0,N,        0,0);
    tbl[18] = mk(0,0,0,N,    1,0,0,0,      0,0,0,0,N,        N,0);
    tbl[19] = mk(0,0,0,N,    1,0,0,0,      0,0,0,0,N,        N,1);
    tbl[20] = mk(1,1,0,N,    0,0,0,0,      0,0,0,0,N,        N,1);
    tbl[21] = mk(0,0,1,3,    0,0,0,0,      0,0,0,0,N,        N,1);
    tbl[22] = mk(1,0,0,3,    0,0,0,0,      0,0,0,0,N,        N,1);
    tbl[23] = mk(0,0,1,3,    0,0,0,0,      1,3,0,0,N,        N,1);
    tbl[24] = mk(0,0,0,N,    0,0,1,12'o55, 1,3,0,1,12'o55,   N,1);
    tbl[25] = mk(0,0,0,N,    0,0,1,12'o66, 1,3,0,1,12'o66,   N,1);
    tbl[26] = mk(0,0,0,N,    0,0,0,0,      1,3,0,0,N,        N,1);
    tbl[27] = mk(0,0,0,N,    0,1,0,0,      0,3,1,0,3,        3,1);
    tbl[28] = mk(0,0,0,N,    0,0,0,0,      0,3,0,0,N,        3,1);

    do_reset();
    check("reset_outputs", outs(), {1'b0, 12'd0, 1'b0, 1'b0, N, N, 1'b0});

    // Empty iret straight out of reset.
    drive(0, 0, 0, N, 1, 0, 0, 0);
    check("empty_iret", outs(), {1'b0, 12'd0, 1'b0, 1'b0, N, N, 1'b1});

    do_reset();
    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].ie_set, tbl[i].ie_clr, tbl[i].boundary, tbl[i].ni,
            tbl[i].iret, tbl[i].int_ack, tbl[i].sw_create, tbl[i].sw_data);
      check($sformatf("row%0d", i), outs(), tbl[i].exp);
    end

    // Reset while a request is outstanding.
    drive(0, 0, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 0, 0, 0);
    check("mid_req_before_reset", {39'd0, int_req}, 40'd1);
    @(negedge clk);
    rst_n = 1'b0;
    int_ack = 1'b1;
    #1;
    check("async_reset_drop", outs(), {1'b0, 12'd0, 1'b0, 1'b0, N, N, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 1, 1, 0, 1, 0, 0);
    check("no_dismiss_after_reset", outs(), {1'b0, 12'd0, 1'b0, 1'b0, N, N, 1'b0});
    drive(0, 0, 0, N, 1, 0, 0, 0);
    check("stack_empty_after_reset", {39'd0, nest_err}, 40'd1);

`ifdef INTSEQ_ACK_TIMEOUT_EN
    begin
      int highs = 0;
      do_reset();
      drive(1, 0, 0, N, 0, 0, 0, 0);
      drive(0, 0, 1, 6, 0, 0, 0, 0);
      for (int k = 0; k < 63; k++) begin
        idle_step();
        if (int_req) highs++;
      end
      check("req_held_63", 40'(highs), 40'd63);
      check("timeout_not_yet", {39'd0, ack_timeout}, 40'd0);
      idle_step();
      check("timeout_drop", {38'd0, int_req, ack_timeout}, 40'd1);
      check("timeout_no_push", {28'd0, cur_level}, {28'd0, N});
      idle_step();
      check("timeout_sticky", {38'd0, ctrl_dismiss, ack_timeout}, 40'd1);
    end
`else
    idle_step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
